// File: rtl/i2s_audio_capture_pkg.sv
// Shared audio definitions: sample/word widths, CTS range and the {right, left} packing.
package i2s_audio_capture_pkg;

   localparam int SAMPLE_WIDTH    = 16;
   localparam int FIFO_WORD_WIDTH = 2 * SAMPLE_WIDTH;
   localparam int BIT_CNT_WIDTH   = $clog2(SAMPLE_WIDTH + 1);
   localparam int CTS_WIDTH       = 20;
   localparam logic [CTS_WIDTH-1:0] CTS_MAX = '1;

   typedef struct packed {
      logic [SAMPLE_WIDTH-1:0] right;
      logic [SAMPLE_WIDTH-1:0] left;
   } sample_word_t;

   function automatic logic [CTS_WIDTH-1:0] cts_sat_inc(input logic [CTS_WIDTH-1:0] v);
      return (v == CTS_MAX) ? v : v + CTS_WIDTH'(1);
   endfunction

endpackage

// File: rtl/i2s_audio_capture_fifo.sv
// Synchronous sample FIFO, 1-cycle registered read; a push into a full FIFO without a
// simultaneous pop is dropped and flagged in a sticky overflow bit.
module audio_sample_fifo
   import i2s_audio_capture_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = FIFO_WORD_WIDTH
)
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_empty,
   output logic             o_full,
   output logic [WIDTH-1:0] o_pop_data,
   output logic             o_overflow
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_pop_data;
   logic             r_overflow;

   logic w_full;
   logic w_pop;
   logic w_accept;
   logic w_drop;

   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign w_pop    = i_pop && (r_count != '0);
   // A full FIFO still takes a push when the same cycle frees a slot.
   assign w_accept = i_push && (!w_full || w_pop);
   assign w_drop   = i_push && w_full && !w_pop;

   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_pop_data <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + AW'(1);
            r_pop_data <= r_mem[r_rd_ptr];
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_empty    = (r_count == '0);
   assign o_full     = w_full;
   assign o_pop_data = r_pop_data;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/i2s_audio_capture.sv
// I2S oversampling deserializer feeding a stereo sample FIFO, plus a CTS meter.
// Samples enter the FIFO 1 cycle after the right-word BCLK edge is detected; full FIFO drops.
module i2s_audio_capture
   import i2s_audio_capture_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2
)
(
   input  logic                       i_pixelClock,
   input  logic                       i_reset,
   input  logic                       i_i2sBclk,
   input  logic                       i_i2sLrclk,
   input  logic                       i_i2sData,
   input  logic [7:0]                 i_samplesPerRegenPacket,
   input  logic                       i_sampleFifoReadEnable,
   output logic                       o_sampleFifoEmpty,
   output logic [FIFO_WORD_WIDTH-1:0] o_sampleFifoReadData,
   output logic [CTS_WIDTH-1:0]       o_cts,
   output logic                       o_ctsValid,
   output logic                       o_overflow
);

   localparam logic [BIT_CNT_WIDTH-1:0] SAMPLE_BITS = BIT_CNT_WIDTH'(SAMPLE_WIDTH);

   logic [SYNC_STAGES-1:0]   r_bclk_sync;
   logic [SYNC_STAGES-1:0]   r_lrclk_sync;
   logic [SYNC_STAGES-1:0]   r_data_sync;
   logic                     r_bclk_prev;
   logic [SAMPLE_WIDTH-1:0]  r_shift;
   logic [BIT_CNT_WIDTH-1:0] r_bit_count;
   logic                     r_lr_prev;
   logic                     r_aligned;
   logic [SAMPLE_WIDTH-1:0]  r_left_hold;
   logic                     r_left_valid;
   logic                     r_push;
   sample_word_t             r_push_data;
   logic [CTS_WIDTH-1:0]     r_cycle_count;
   logic [7:0]               r_win_count;
   logic [CTS_WIDTH-1:0]     r_cts;
   logic                     r_cts_valid;

   logic                     w_bclk;
   logic                     w_lrclk;
   logic                     w_data;
   logic                     w_bit_edge;
   logic                     w_lr_change;
   logic                     w_room;
   logic [SAMPLE_WIDTH-1:0]  w_shift_next;
   logic [BIT_CNT_WIDTH-1:0] w_count_next;
   logic [SAMPLE_WIDTH-1:0]  w_word;
   logic [7:0]               w_win_next;
   logic                     w_fifo_full;

   always_ff @(posedge i_pixelClock or posedge i_reset) begin
      if (i_reset) begin
         r_bclk_sync  <= '0;
         r_lrclk_sync <= '0;
         r_data_sync  <= '0;
      end else begin
         r_bclk_sync[0]  <= i_i2sBclk;
         r_lrclk_sync[0] <= i_i2sLrclk;
         r_data_sync[0]  <= i_i2sData;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_bclk_sync[i]  <= r_bclk_sync[i-1];
            r_lrclk_sync[i] <= r_lrclk_sync[i-1];
            r_data_sync[i]  <= r_data_sync[i-1];
         end
      end
   end

   assign w_bclk       = r_bclk_sync[SYNC_STAGES-1];
   assign w_lrclk      = r_lrclk_sync[SYNC_STAGES-1];
   assign w_data       = r_data_sync[SYNC_STAGES-1];
   assign w_bit_edge   = w_bclk && !r_bclk_prev;
   assign w_lr_change  = (w_lrclk != r_lr_prev);
   assign w_room       = (r_bit_count < SAMPLE_BITS);
   assign w_shift_next = w_room ? {r_shift[SAMPLE_WIDTH-2:0], w_data} : r_shift;
   assign w_count_next = w_room ? r_bit_count + BIT_CNT_WIDTH'(1) : r_bit_count;
   // The LSB of the finishing word arrives on the same edge as the LRCLK change,
   // so the completed word already includes this edge's bit; short words left-justify.
   assign w_word       = w_shift_next << (SAMPLE_BITS - w_count_next);

   always_ff @(posedge i_pixelClock or posedge i_reset) begin
      if (i_reset) begin
         r_bclk_prev  <= 1'b0;
         r_shift      <= '0;
         r_bit_count  <= '0;
         r_lr_prev    <= 1'b0;
         r_aligned    <= 1'b0;
         r_left_hold  <= '0;
         r_left_valid <= 1'b0;
         r_push       <= 1'b0;
         r_push_data  <= '0;
      end else begin
         r_bclk_prev <= w_bclk;
         r_push      <= 1'b0;
         if (w_bit_edge) begin
            r_shift     <= w_shift_next;
            r_bit_count <= w_count_next;
            if (w_lr_change) begin
               r_shift     <= '0;
               r_bit_count <= '0;
               r_lr_prev   <= w_lrclk;
               r_aligned   <= 1'b1;
               if (r_aligned) begin
                  if (!r_lr_prev) begin
                     r_left_hold  <= w_word;
                     r_left_valid <= 1'b1;
                  end else if (r_left_valid) begin
                     r_push       <= 1'b1;
                     r_push_data  <= '{right: w_word, left: r_left_hold};
                     r_left_valid <= 1'b0;
                  end
               end
            end
         end
      end
   end

   assign w_win_next = r_win_count + 8'd1;

   // Dropped pushes still count toward the window: the source rate is what CTS measures.
   always_ff @(posedge i_pixelClock or posedge i_reset) begin
      if (i_reset) begin
         r_cycle_count <= '0;
         r_win_count   <= '0;
         r_cts         <= '0;
         r_cts_valid   <= 1'b0;
      end else if (i_samplesPerRegenPacket == 8'd0) begin
         r_cycle_count <= '0;
         r_win_count   <= '0;
      end else if (r_push && (w_win_next == i_samplesPerRegenPacket)) begin
         r_cts         <= cts_sat_inc(r_cycle_count);
         r_cts_valid   <= 1'b1;
         r_cycle_count <= '0;
         r_win_count   <= '0;
      end else begin
         r_cycle_count <= cts_sat_inc(r_cycle_count);
         if (r_push) begin
            r_win_count <= w_win_next;
         end
      end
   end

   audio_sample_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FIFO_WORD_WIDTH)
   ) u_fifo (
      .i_clk       (i_pixelClock),
      .i_rst       (i_reset),
      .i_push      (r_push),
      .i_push_data (r_push_data),
      .i_pop       (i_sampleFifoReadEnable),
      .o_empty     (o_sampleFifoEmpty),
      .o_full      (w_fifo_full),
      .o_pop_data  (o_sampleFifoReadData),
      .o_overflow  (o_overflow)
   );

   assign o_cts      = r_cts;
   assign o_ctsValid = r_cts_valid;

endmodule

// File: doc/i2s_audio_capture.md
Name: i2s_audio_capture

Overview:
Upstream feeder for the HDMI horizontal-blanking data island stage. Oversamples an external I2S stream in the pixel clock domain and assembles 16-bit stereo samples. Buffers the samples in a small synchronous FIFO whose read side matches the data island stage's sample-FIFO interface. Also measures CTS, the pixel clocks elapsed per audio clock regeneration period, for the Audio Clock Regeneration packet.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 4
SYNC_STAGES, 2, synchronizer flops on each I2S input

Ports:
pixelClock  in  1  sole clock; TMDS pixel clock
reset  in  1  asynchronous, active-high reset
i2sBclk  in  1  I2S bit clock, asynchronous; frequency must be at most pixelClock/4
i2sLrclk  in  1  I2S word select, asynchronous; 0 = left, 1 = right
i2sData  in  1  I2S serial data, MSB first, one-BCLK delay after LRCLK edge
samplesPerRegenPacket  in  8  samples per CTS measurement window (N/128); 0 disables the meter
sampleFifoReadEnable  in  1  pop request from the data island stage
sampleFifoEmpty  out  1  FIFO holds no samples
sampleFifoReadData  out  32  {right[15:0], left[15:0]}; registered
cts  out  20  last measured CTS value
ctsValid  out  1  at least one CTS measurement completed since reset
overflow  out  1  sticky; a sample was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release): sampleFifoEmpty=1, sampleFifoReadData=0, cts=0, ctsValid=0, overflow=0; all pointers, counters and flags cleared.
- Input capture:
  - All three I2S inputs pass through SYNC_STAGES flops.
  - A BCLK rising edge is detected as synced bclk=1 with the previous synced value 0.
  - All capture actions occur only on a detected edge.
- Per edge, in this order:
  - bitCount<16: shift synced data into the shift register, bitCount++.
  - Synced lrclk differs from lrPrev: the word of channel lrPrev is complete.
    - Left completes: hold it in leftHold, leftValid=1.
    - Right completes with leftValid=1: push {shift, leftHold} and clear leftValid.
    - Any completion: bitCount=0, lrPrev updated, aligned=1.
  - Completions while aligned=0 are discarded. The first partial word after reset is never pushed.
- Word sizes: words longer than 16 bits keep their 16 MSBs. Words shorter than 16 bits are left-justified and zero-padded.
- Latency: a sample is pushed 1 cycle after the detected BCLK edge carrying the right-channel completion. sampleFifoEmpty deasserts the cycle after the push.
- FIFO:
  - Occupancy counter runs 0..DEPTH.
  - Pop: sampleFifoReadEnable=1 while sampleFifoEmpty=0. sampleFifoReadData updates on the next edge, giving 1-cycle read latency.
  - readEnable while empty is ignored; the pointer and data are unchanged.
  - Push and pop in the same cycle: both succeed, including when full. Occupancy is unchanged.
  - Push when full without pop: the sample is dropped, overflow=1 (sticky until reset), and the FIFO is unchanged.
  - Pointers wrap modulo DEPTH.
- CTS meter:
  - cycleCount increments every pixelClock and saturates at 20'hFFFFF.
  - winCount increments on each accepted or dropped push.
  - Push with winCount+1 == samplesPerRegenPacket: cts <= cycleCount+1 (saturating), ctsValid=1, cycleCount=0, winCount=0.
  - samplesPerRegenPacket=0: the meter is frozen; cycleCount and winCount are held at 0 and cts holds its value.
  - samplesPerRegenPacket changed mid-window: the new value applies from the next compare. If winCount already exceeds it, the window continues until the 8-bit winCount wraps.
- Reset asserted mid-word or mid-window: all state is cleared immediately. Capture resumes only after the next LRCLK transition.

Decomposition:
- Shared audio package holds:
  - SAMPLE_WIDTH=16 and FIFO_WORD_WIDTH=32 constants.
  - CTS_WIDTH=20 and CTS_MAX constants.
  - The sample word packing order {right, left}.
- One natural sub-module, audio_sample_fifo. It is a synchronous FIFO with the push/pop/overflow rules above, parameterised by DEPTH. It is reused by any future audio source.
- The synchronizers and the deserializer stay inline.

Test Plan:
- I2S 16-bit words, BCLK=pixelClock/8, L=16'h1234 then R=16'hABCD -> after R completes one FIFO entry 32'hABCD1234, sampleFifoEmpty falls; readEnable -> readData=32'hABCD1234 next cycle, empty rises.
- 24-bit words L=24'h89ABCD, R=24'h123456 -> entry 32'h12348 9AB (i.e. 32'h123489AB); low bytes discarded.
- Reset released mid-right-word, then full frames of L=1/R=2 -> the first partial frame is not pushed; the first entry is 32'h00020001.
- DEPTH=8, push 9 frames with no reads -> 8 entries, overflow=1; then push and pop in the same cycle while full -> the new sample is accepted and occupancy stays 8.
- samplesPerRegenPacket=48, one frame every 1547 pixel clocks (74.25 MHz / 48 kHz, rounded) -> after 48 pushes cts=74256 (48×1547), ctsValid=1; samplesPerRegenPacket=0 -> cts frozen.
- readEnable pulsed while empty -> readData and pointers unchanged; no underflow.
